// File: rtl/darksocv_bus_arbiter.sv
// darksocv_bus_arbiter: round-robin sharing of one target port between the Wishbone slave and the core data bus
module darksocv_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        core_rd_i,
    input  logic        core_wr_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_adr_i,
    input  logic [31:0] core_dat_i,
    output logic [31:0] core_dat_o,
    output logic        core_hlt_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_core_q, last_core_d;
    logic        we_q, we_d, to_q, to_d, abort_q, abort_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic [31:0] wbs_dat_q, wbs_dat_d, core_dat_q, core_dat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_req, core_req, pick_core, wb_done, core_done;
    logic [31:0] rsp_data;
    assign wb_req     = wbs_cyc_i & wbs_stb_i;
    assign core_req   = core_rd_i | core_wr_i;
    assign pick_core  = core_req & (~wb_req | ~last_core_q);
    assign rsp_data   = to_q ? ERR_DATA : rdata_q;
    assign wb_done    = (state_q == RESP) & grant_q[0] & ~abort_q;
    assign core_done  = (state_q == RESP) & grant_q[1];
    assign wbs_ack_o  = wb_done;
    assign wbs_dat_o  = wb_done ? rsp_data : wbs_dat_q;
    assign core_dat_o = core_done ? rsp_data : core_dat_q;
    assign core_hlt_o = XRES & core_req & ~core_done;
    assign mem_req_o  = state_q == BUSY;
    assign mem_we_o   = we_q;
    assign mem_be_o   = be_q;
    assign mem_adr_o  = adr_q;
    assign mem_dat_o  = dat_q;
    assign grant_o    = grant_q;
    assign timeout_o  = (state_q == RESP) & to_q;
    // next-state: grant in IDLE, wait for ack or timeout in BUSY, deliver and release in RESP
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_core_d = last_core_q;
        we_d        = we_q;
        be_d        = be_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        to_d        = to_q;
        abort_d     = abort_q;
        wbs_dat_d   = wbs_dat_o;
        core_dat_d  = core_dat_o;
        case (state_q)
            IDLE: if (wb_req | core_req) begin
                grant_d = pick_core ? 2'b10 : 2'b01;
                we_d    = pick_core ? core_wr_i : wbs_we_i;
                be_d    = pick_core ? core_be_i : wbs_sel_i;
                adr_d   = pick_core ? core_adr_i : wbs_adr_i;
                dat_d   = pick_core ? core_dat_i : wbs_dat_i;
                to_d    = 1'b0;
                abort_d = 1'b0;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q + 16'd1;
                abort_d = abort_q | (grant_q[0] & ~wb_req);
                if (mem_ack_i) begin
                    rdata_d = mem_dat_i;
                    state_d = RESP;
                end else if (cnt_q == TMAX) begin
                    to_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_core_d = grant_q[1];
                grant_d     = 2'b00;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state register; reset abandons any in-flight access
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_core_q <= 1'b1;
            we_q        <= 1'b0;
            be_q        <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            to_q        <= 1'b0;
            abort_q     <= 1'b0;
            wbs_dat_q   <= '0;
            core_dat_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_core_q <= last_core_d;
            we_q        <= we_d;
            be_q        <= be_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            to_q        <= to_d;
            abort_q     <= abort_d;
            wbs_dat_q   <= wbs_dat_d;
            core_dat_q  <= core_dat_d;
        end
    end
endmodule
